// File: rtl/register_bank.sv
// Parametrised general-register bank with a shared function select, write mask,
// registered Zero/Carry flags and two combinational read ports.
module register_bank #(
  parameter int unsigned       WIDTH     = 16,
  parameter int unsigned       NUM_REGS  = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       SELW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [3:0]          FunSel,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [WIDTH-1:0]    I,
  input  logic [SELW-1:0]     OutASel,
  input  logic [SELW-1:0]     OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic                Z,
  output logic                C
);

  localparam int unsigned HALF = WIDTH / 2;

  typedef enum logic [3:0] {
    OP_DEC  = 4'b0000,
    OP_INC  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_CLR  = 4'b0011,
    OP_LDL  = 4'b0100,
    OP_WRL  = 4'b0101,
    OP_WRH  = 4'b0110,
    OP_SEXT = 4'b0111,
    OP_LSL  = 4'b1000,
    OP_LSR  = 4'b1001,
    OP_ASR  = 4'b1010,
    OP_ROL  = 4'b1011,
    OP_ROR  = 4'b1100,
    OP_NOT  = 4'b1101,
    OP_HLD0 = 4'b1110,
    OP_HLD1 = 4'b1111
  } op_e;

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [WIDTH-1:0]    nxt  [NUM_REGS];
  logic [NUM_REGS-1:0] cout;
  logic [WIDTH-1:0]    src_nxt;
  logic                src_c;
  logic                is_hold;
  logic                c_upd;
  logic                any_sel;
  op_e                 op;

  assign op = op_e'(FunSel);

  // Candidate next value and carry-out for every register from its own old value.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      nxt[k]  = regs[k];
      cout[k] = 1'b0;
      case (op)
        OP_DEC: begin
          nxt[k]  = regs[k] - WIDTH'(1);
          cout[k] = (regs[k] == '0);
        end
        OP_INC: begin
          nxt[k]  = regs[k] + WIDTH'(1);
          cout[k] = &regs[k];
        end
        OP_LD:   nxt[k] = I;
        OP_CLR:  nxt[k] = '0;
        OP_LDL:  nxt[k] = {{HALF{1'b0}}, I[HALF-1:0]};
        OP_WRL:  nxt[k] = {regs[k][WIDTH-1:HALF], I[HALF-1:0]};
        OP_WRH:  nxt[k] = {I[WIDTH-1:HALF], regs[k][HALF-1:0]};
        OP_SEXT: nxt[k] = {{HALF{I[HALF-1]}}, I[HALF-1:0]};
        OP_LSL: begin
          nxt[k]  = {regs[k][WIDTH-2:0], 1'b0};
          cout[k] = regs[k][WIDTH-1];
        end
        OP_LSR: begin
          nxt[k]  = {1'b0, regs[k][WIDTH-1:1]};
          cout[k] = regs[k][0];
        end
        OP_ASR: begin
          nxt[k]  = {regs[k][WIDTH-1], regs[k][WIDTH-1:1]};
          cout[k] = regs[k][0];
        end
        OP_ROL: begin
          nxt[k]  = {regs[k][WIDTH-2:0], regs[k][WIDTH-1]};
          cout[k] = regs[k][WIDTH-1];
        end
        OP_ROR: begin
          nxt[k]  = {regs[k][0], regs[k][WIDTH-1:1]};
          cout[k] = regs[k][0];
        end
        OP_NOT:  nxt[k] = ~regs[k];
        default: nxt[k] = regs[k];
      endcase
    end
  end

  // Only arithmetic and shift/rotate ops produce a carry; hold touches nothing.
  always_comb begin
    is_hold = (op == OP_HLD0) || (op == OP_HLD1);
    c_upd   = 1'b0;
    case (op)
      OP_DEC, OP_INC, OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: c_upd = 1'b1;
      default: c_upd = 1'b0;
    endcase
  end

  // Flags follow the lowest-indexed selected register.
  always_comb begin
    any_sel = |RegSel;
    src_nxt = nxt[0];
    src_c   = cout[0];
    for (int k = int'(NUM_REGS) - 1; k >= 0; k--) begin
      if (RegSel[k]) begin
        src_nxt = nxt[k];
        src_c   = cout[k];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
      Z <= 1'b0;
      C <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (RegSel[k]) regs[k] <= nxt[k];
      end
      if (any_sel && !is_hold) begin
        Z <= (src_nxt == '0);
        if (c_upd) C <= src_c;
      end
    end
  end

  // Out-of-range selects read as zero rather than an undefined element.
  assign OutA = (32'(OutASel) < NUM_REGS) ? regs[OutASel] : '0;
  assign OutB = (32'(OutBSel) < NUM_REGS) ? regs[OutBSel] : '0;

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank: default 16x4 build plus an 8x3 build.
module tb_register_bank;

  logic        clk;
  logic        rst;
  logic [3:0]  fun;
  logic [3:0]  rsel;
  logic [15:0] din;
  logic [1:0]  asel, bsel;
  logic [15:0] outa, outb;
  logic        z, c;

  logic        s_rst;
  logic [3:0]  s_fun;
  logic [2:0]  s_rsel;
  logic [7:0]  s_din;
  logic [1:0]  s_asel, s_bsel;
  logic [7:0]  s_outa, s_outb;
  logic        s_z, s_c;

  int n_checks;
  int n_fail;

  register_bank dut (
    .Clock(clk), .Reset(rst), .FunSel(fun), .RegSel(rsel), .I(din),
    .OutASel(asel), .OutBSel(bsel), .OutA(outa), .OutB(outb), .Z(z), .C(c)
  );

  register_bank #(.WIDTH(8), .NUM_REGS(3)) dut_s (
    .Clock(clk), .Reset(s_rst), .FunSel(s_fun), .RegSel(s_rsel), .I(s_din),
    .OutASel(s_asel), .OutBSel(s_bsel), .OutA(s_outa), .OutB(s_outb), .Z(s_z), .C(s_c)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read register k on both ports of the large DUT.
  task automatic chk_reg(input string tag, input logic [1:0] k, input logic [15:0] exp);
    asel = k;
    bsel = k;
    #1;
    check({tag, "_A"}, outa, exp);
    check({tag, "_B"}, outb, exp);
  endtask

  task automatic chk_flags(input string tag, input logic ez, input logic ec);
    check({tag, "_Z"}, 16'(z), 16'(ez));
    check({tag, "_C"}, 16'(c), 16'(ec));
  endtask

  task automatic op(input logic [3:0] f, input logic [3:0] m, input logic [15:0] d);
    fun  = f;
    rsel = m;
    din  = d;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; fun = 4'b0010; rsel = 4'b1111; din = 16'h1234; asel = '0; bsel = '0;
    s_rst = 1'b1; s_fun = 4'b0001; s_rsel = 3'b111; s_din = 8'h5A; s_asel = '0; s_bsel = '0;

    // Reset beats a simultaneous load.
    step();
    rst = 1'b0;
    s_rst = 1'b0;
    for (int k = 0; k < 4; k++) chk_reg("rst", 2'(k), 16'h0000);
    chk_flags("rst", 1'b0, 1'b0);

    // Load all-ones into R0/R1, then increment wraps to zero.
    op(4'b0010, 4'b0011, 16'hFFFF);
    chk_reg("ld_r0", 2'd0, 16'hFFFF);
    chk_flags("ld", 1'b0, 1'b0);
    op(4'b0001, 4'b0011, 16'h0000);
    chk_reg("inc_r0", 2'd0, 16'h0000);
    chk_reg("inc_r1", 2'd1, 16'h0000);
    chk_reg("inc_r2", 2'd2, 16'h0000);
    chk_reg("inc_r3", 2'd3, 16'h0000);
    chk_flags("inc", 1'b1, 1'b1);

    // ASR then ROL on R2.
    op(4'b0010, 4'b0100, 16'h8001);
    chk_reg("ld_r2", 2'd2, 16'h8001);
    chk_flags("ld_r2", 1'b0, 1'b1);
    op(4'b1010, 4'b0100, 16'h0000);
    chk_reg("asr", 2'd2, 16'hC000);
    chk_flags("asr", 1'b0, 1'b1);
    op(4'b1011, 4'b0100, 16'h0000);
    chk_reg("rol", 2'd2, 16'h8001);
    chk_flags("rol", 1'b0, 1'b1);

    // Increment R1 from zero clears C.
    op(4'b0001, 4'b0010, 16'h0000);
    chk_reg("inc1", 2'd1, 16'h0001);
    chk_flags("inc1", 1'b0, 1'b0);

    // Half-word ops on R3; C is left alone.
    op(4'b0111, 4'b1000, 16'h12F0);
    chk_reg("sext", 2'd3, 16'hFFF0);
    chk_flags("sext", 1'b0, 1'b0);
    op(4'b0110, 4'b1000, 16'hAB00);
    chk_reg("wrh", 2'd3, 16'hABF0);
    op(4'b0101, 4'b1000, 16'h0011);
    chk_reg("wrl", 2'd3, 16'hAB11);
    op(4'b0100, 4'b1000, 16'h5566);
    chk_reg("ldl", 2'd3, 16'h0066);
    op(4'b1101, 4'b1000, 16'h0000);
    chk_reg("not", 2'd3, 16'hFF99);
    chk_flags("not", 1'b0, 1'b0);

    // Clear R2 and R3 together; flag source is R2.
    op(4'b0011, 4'b1100, 16'h0000);
    chk_reg("clr2", 2'd2, 16'h0000);
    chk_reg("clr3", 2'd3, 16'h0000);
    chk_flags("clr", 1'b1, 1'b0);

    // Decrement wraps with borrow.
    op(4'b0000, 4'b0001, 16'h0000);
    chk_reg("dec", 2'd0, 16'hFFFF);
    chk_flags("dec", 1'b0, 1'b1);

    // Same decrement with reset asserted: reset wins.
    op(4'b0011, 4'b0001, 16'h0000);
    chk_flags("clr0", 1'b1, 1'b1);
    rst = 1'b1;
    op(4'b0000, 4'b0001, 16'h0000);
    rst = 1'b0;
    chk_reg("rstp_r0", 2'd0, 16'h0000);
    chk_reg("rstp_r1", 2'd1, 16'h0000);
    chk_flags("rstp", 1'b0, 1'b0);

    // LSL, then empty mask and hold leave everything untouched.
    op(4'b0010, 4'b0010, 16'h80FF);
    op(4'b1000, 4'b0010, 16'h0000);
    chk_reg("lsl", 2'd1, 16'h01FE);
    chk_flags("lsl", 1'b0, 1'b1);
    op(4'b0011, 4'b0000, 16'h0000);
    chk_reg("nosel", 2'd1, 16'h01FE);
    chk_flags("nosel", 1'b0, 1'b1);
    op(4'b1111, 4'b0010, 16'h0000);
    chk_reg("hold", 2'd1, 16'h01FE);
    chk_flags("hold", 1'b0, 1'b1);

    // 8-bit, 3-register build.
    s_fun = 4'b0010; s_rsel = 3'b111; s_din = 8'hA5;
    step();
    s_asel = 2'd2; s_bsel = 2'd3;
    #1;
    check("s_ld", 16'(s_outa), 16'h00A5);
    check("s_oob_b", 16'(s_outb), 16'h0000);
    s_fun = 4'b1010;
    step();
    s_asel = 2'd0;
    #1;
    check("s_asr", 16'(s_outa), 16'h00D2);
    check("s_asr_C", 16'(s_c), 16'h0001);
    s_fun = 4'b1110;
    step();
    s_asel = 2'd3; s_bsel = 2'd1;
    #1;
    check("s_oob_a", 16'(s_outa), 16'h0000);
    check("s_hold", 16'(s_outb), 16'h00D2);
    check("s_hold_Z", 16'(s_z), 16'h0000);
    check("s_hold_C", 16'(s_c), 16'h0001);
    s_fun = 4'b1001; s_rsel = 3'b100;
    step();
    s_asel = 2'd2; s_bsel = 2'd0;
    #1;
    check("s_lsr", 16'(s_outa), 16'h0069);
    check("s_lsr_r0", 16'(s_outb), 16'h00D2);
    check("s_lsr_C", 16'(s_c), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised bank of NUM_REGS general registers, each WIDTH bits wide, written through a shared 4-bit function select and a one-hot-style write mask.
- Extends the 8-operation single-register set with shifts, rotates, complement and hold, plus a synchronous reset.
- Adds Zero/Carry flags and two combinational read ports.
- Serves as the register-file stage feeding the ALU operand muxes.

Parameters:
- WIDTH, 16, register width in bits; must be even and ≥4; HALF = WIDTH/2.
- NUM_REGS, 4, number of registers; ≥2.
- RESET_VAL, 0, value loaded into every register on reset.
- SELW, $clog2(NUM_REGS), width of the read-select ports (derived).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous active-high reset.
- FunSel  in  4  operation applied to every enabled register.
- RegSel  in  NUM_REGS  write-enable mask; bit k enables register k.
- I  in  WIDTH  load data.
- OutASel  in  SELW  read port A index.
- OutBSel  in  SELW  read port B index.
- OutA  out  WIDTH  contents of register OutASel.
- OutB  out  WIDTH  contents of register OutBSel.
- Z  out  1  zero flag.
- C  out  1  carry/shift-out flag.

Behaviour:
- Clock is the only clock. Reset is synchronous and active-high.
- Reset (sampled at rising edge of Clock): all registers ← RESET_VAL; Z ← 0; C ← 0. Reset overrides FunSel and RegSel. Reset asserted mid-sequence discards that cycle's operation.
- Each rising edge without reset: every register k with RegSel[k]=1 gets R' = f(FunSel, R_k, I). Unselected registers hold. All selected registers update in the same cycle, each from its own old value.
- FunSel encoding (L = low HALF bits, H = high HALF bits):
  - 0000 R-1, wraps 0 → all-ones.
  - 0001 R+1, wraps all-ones → 0.
  - 0010 load I.
  - 0011 clear to 0.
  - 0100 {0, I.L} (zero-extend low half).
  - 0101 R.L ← I.L, R.H held.
  - 0110 R.H ← I.H, R.L held.
  - 0111 sign-extend I.L, fill bit I[HALF-1].
  - 1000 LSL by 1, 0 in at LSB.
  - 1001 LSR by 1, 0 in at MSB.
  - 1010 ASR by 1, MSB replicated.
  - 1011 ROL by 1.
  - 1100 ROR by 1.
  - 1101 bitwise complement.
  - 1110, 1111 hold; no register or flag change.
- Flags are registered and update on the same edge as the write. The flag source is the lowest-indexed register with RegSel bit set; its new value R' drives them.
  - Z = (R'==0), for every op except hold.
  - C:
    - inc: 1 iff old R was all-ones.
    - dec: 1 iff old R was 0 (borrow).
    - LSL, ROL: old MSB.
    - LSR, ASR, ROR: old LSB.
    - loads, clear, complement: C unchanged.
  - RegSel = 0 or hold op: Z and C unchanged.
- Reads are combinational and show the current register value. A write is visible on OutA/OutB the cycle after its edge. No read-during-write bypass.
- A read select ≥ NUM_REGS returns 0.
- No X propagation from unselected registers. RegSel may have any number of bits set.

Test Plan:
- Reset=1 for one edge with arbitrary FunSel/RegSel → all OutA/OutB reads = 0x0000; Z=0, C=0.
- RegSel=0011, FunSel=0010, I=0xFFFF; next edge FunSel=0001 → R0=R1=0x0000, Z=1, C=1; R2/R3 still 0x0000 (they were never written).
- R2 loaded with 0x8001, then FunSel=1010 (ASR) → R2=0xC000, C=1, Z=0. Then FunSel=1011 (ROL) → R2=0x8001, C=1.
- I=0x12F0, FunSel=0111 on R3 → 0xFFF0. Then FunSel=0110 with I=0xAB00 → R3=0xABF0. C holds its prior value throughout.
- R0=0x0000, FunSel=0000 (dec) → R0=0xFFFF, C=1. Same edge with Reset=1 instead → R0=0x0000, C=0 (reset priority).
- NUM_REGS=3, WIDTH=8 build: OutASel=3 → OutA=0x00. FunSel=1110 with RegSel=111 → registers and flags unchanged.
